uart_rx_ctrl: RTL and testbench

- Oversampled UART receive controller. It sequences start detection, mid-bit sampling, data shift, optional parity check and stop check.
- It presents each received byte on a valid/ready handshake with error flags.
- It sits between the pad-side serial input and the consumer of received bytes.
- It owns all receive counters and the receive FSM, so the datapath needs no separate sequencer.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Holds the receive FSM state type and mid-start count helper.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Tick count at which the start bit is re-checked (half a bit in).
  function automatic int midStart(input int os);
    return os / 2 - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial input, resets to line idle (1).
// Ports: clk, reset (async active-low), d (async in), q (synchronized).
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Oversampled UART receiver: start/data/parity/stop FSM plus a
// valid/ready output register with frame/parity errors and sticky overrun.
// Ports: clk, reset, tick, rx, parity_en, parity_odd, ready, clr_err ->
//        data, valid, frame_err, parity_err, overrun, busy.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 ready,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(midStart(OVERSAMPLE));
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  logic                 rxS;
  rx_state_t            state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitCnt;
  logic [DATA_BITS-1:0] shReg;
  logic                 xorAcc;
  logic                 cfgParEn;
  logic                 cfgParOdd;
  logic                 perr;
  logic                 ferr;
  logic                 complete;

  uart_rx_sync uSync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rxS)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitCnt    <= '0;
      shReg     <= '0;
      xorAcc    <= 1'b0;
      cfgParEn  <= 1'b0;
      cfgParOdd <= 1'b0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      complete  <= 1'b0;
    end else begin
      complete <= 1'b0;
      if (tick) begin
        unique case (state)
          IDLE: begin
            if (!rxS) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            if (cnt == CNT_MID) begin
              if (!rxS) begin
                state     <= DATA;
                cnt       <= '0;
                bitCnt    <= '0;
                xorAcc    <= 1'b0;
                perr      <= 1'b0;
                cfgParEn  <= parity_en;
                cfgParOdd <= parity_odd;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA: begin
            if (cnt == CNT_LAST) begin
              shReg  <= {rxS, shReg[DATA_BITS-1:1]};
              xorAcc <= xorAcc ^ rxS;
              cnt    <= '0;
              bitCnt <= bitCnt + 1'b1;
              if (bitCnt == BIT_LAST) begin
                state <= cfgParEn ? PARITY : STOP;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          PARITY: begin
            if (cnt == CNT_LAST) begin
              perr  <= ((xorAcc ^ rxS) != cfgParOdd);
              cnt   <= '0;
              state <= STOP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STOP: begin
            if (cnt == CNT_LAST) begin
              ferr     <= !rxS;
              complete <= 1'b1;
              cnt      <= '0;
              state    <= rxS ? IDLE : BREAK;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          BREAK: begin
            // A held-low line must go high before a new start counts.
            if (rxS) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data       <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (complete && (!valid || ready)) begin
        data       <= shReg;
        frame_err  <= ferr;
        parity_err <= perr;
        valid      <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      // Dropping a frame beats a simultaneous clear.
      if (complete && valid && !ready) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a frame-level model.
// Drives serial frames bit by bit and compares each presented byte.
module tb_uart_rx_ctrl;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          clk        = 1'b0;
  logic          reset      = 1'b1;
  logic          tick       = 1'b0;
  logic          rx         = 1'b1;
  logic          parity_en  = 1'b0;
  logic          parity_odd = 1'b0;
  logic          ready      = 1'b1;
  logic          clr_err    = 1'b0;
  logic [DB-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          busy;

  int nVec    = 0;
  int nErr    = 0;
  int cyc     = 0;
  int fellCyc = -10;
  logic busyQ  = 1'b0;
  logic validQ = 1'b0;
  bit abortTx = 1'b0;

  typedef struct {
    logic [DB-1:0] d;
    logic          fe;
    logic          pe;
  } rec_t;

  rec_t gotQ[$];

  uart_rx_ctrl #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .ready      (ready),
    .clr_err    (clr_err),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Record every newly presented byte; valid must follow the
  // stop sample (busy falling) by exactly one clock.
  always @(negedge clk) begin
    cyc++;
    if (busyQ && !busy) fellCyc = cyc;
    if (valid && !validQ) begin
      gotQ.push_back('{data, frame_err, parity_err});
      if (!frame_err) chk("latency", cyc - fellCyc, 1);
    end
    busyQ  = busy;
    validQ = valid;
  end

  task automatic waitTicks(input int n);
    int c = 0;
    while (c < n && !abortTx) begin
      @(posedge clk);
      if (tick) c++;
    end
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [DB-1:0] d,
                           input bit pen,
                           input bit pbit,
                           input bit stopB);
    rx = 1'b0;
    waitTicks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      waitTicks(OS);
    end
    if (pen) begin
      rx = pbit;
      waitTicks(OS);
    end
    rx = stopB;
    waitTicks(OS);
    if (abortTx) rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    waitTicks(n);
  endtask

  task automatic checkFrame(input string tag,
                            input logic [DB-1:0] d,
                            input bit pen,
                            input bit odd,
                            input bit pbit,
                            input bit stopB);
    rec_t r;
    int   ones;
    logic pe;
    ones = $countones(d) + int'(pbit);
    pe   = pen && ((ones % 2) != int'(odd));
    chk({tag, "-count"}, gotQ.size(), 1);
    if (gotQ.size() > 0) begin
      r = gotQ.pop_front();
      chk({tag, "-data"}, r.d, d);
      chk({tag, "-ferr"}, r.fe, !stopB);
      chk({tag, "-perr"}, r.pe, pe);
    end
    gotQ.delete();
  endtask

  initial begin
    logic [DB-1:0] d;
    bit pen, odd, pb, sb;
    int k;

    #2 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst-data", data, 0);
    chk("rst-valid", valid, 0);
    chk("rst-errs", {frame_err, parity_err, overrun}, 0);
    chk("rst-busy", busy, 0);
    reset = 1'b1;
    idle(20);

    // 8N1 basic byte
    parity_en = 1'b0;
    sendFrame(8'hA5, 0, 0, 1);
    idle(4);
    checkFrame("a5", 8'hA5, 0, 0, 0, 1);

    // even parity, good then bad parity bit
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    sendFrame(8'h07, 1, 1, 1);
    idle(4);
    checkFrame("par-ok", 8'h07, 1, 0, 1, 1);
    sendFrame(8'h07, 1, 0, 1);
    idle(4);
    checkFrame("par-bad", 8'h07, 1, 0, 0, 1);

    // framing error followed by a long break
    parity_en = 1'b0;
    sendFrame(8'h3C, 0, 0, 0);
    waitTicks(OS * 20);
    chk("brk-busy1", busy, 1);
    waitTicks(OS * 20);
    chk("brk-busy2", busy, 1);
    checkFrame("brk", 8'h3C, 0, 0, 0, 0);
    rx = 1'b1;
    waitTicks(2);
    chk("brk-exit", busy, 0);
    idle(10);
    sendFrame(8'h5A, 0, 0, 1);
    idle(4);
    checkFrame("post-brk", 8'h5A, 0, 0, 0, 1);

    // short low glitch
    rx = 1'b0;
    waitTicks(5);
    rx = 1'b1;
    waitTicks(20);
    chk("glitch-busy", busy, 0);
    chk("glitch-none", gotQ.size(), 0);

    // overrun with ready held low
    ready = 1'b0;
    sendFrame(8'h11, 0, 0, 1);
    idle(4);
    sendFrame(8'h22, 0, 0, 1);
    idle(4);
    checkFrame("ovr-first", 8'h11, 0, 0, 0, 1);
    chk("ovr-valid", valid, 1);
    chk("ovr-hold", data, 8'h11);
    chk("ovr-flag", overrun, 1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("ovr-clr", overrun, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("ovr-drain", valid, 0);

    // ready on the exact complete cycle replaces the held byte
    sendFrame(8'h11, 0, 0, 1);
    idle(4);
    checkFrame("rdy-first", 8'h11, 0, 0, 0, 1);
    fork
      sendFrame(8'h22, 0, 0, 1);
      begin
        k = 0;
        while (!busy && k < 3000) begin
          @(negedge clk);
          k++;
        end
        while (busy && k < 3000) begin
          @(negedge clk);
          k++;
        end
        if (k >= 3000) begin
          chk("rdy-timeout", 0, 1);
        end else begin
          ready = 1'b1;
          @(negedge clk);
          ready = 1'b0;
          chk("rdy-data", data, 8'h22);
          chk("rdy-valid", valid, 1);
          chk("rdy-ovr", overrun, 0);
        end
      end
    join
    ready = 1'b1;
    idle(4);
    chk("rdy-norise", gotQ.size(), 0);
    chk("rdy-drain", valid, 0);

    // reset in the middle of a frame
    fork
      sendFrame(8'h55, 0, 0, 1);
      begin
        waitTicks(OS * 4);
        reset = 1'b0;
        #1;
        chk("mrst-valid", valid, 0);
        chk("mrst-busy", busy, 0);
        abortTx = 1'b1;
      end
    join
    rx = 1'b1;
    abortTx = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    idle(20);
    chk("mrst-none", gotQ.size(), 0);
    sendFrame(8'h9A, 0, 0, 1);
    idle(4);
    checkFrame("mrst-next", 8'h9A, 0, 0, 0, 1);

    // random frames; config is perturbed mid-frame
    for (int n = 0; n < 30; n++) begin
      d   = DB'($urandom);
      pen = 1'($urandom);
      odd = 1'($urandom);
      pb  = (^d) ^ odd;
      if ($urandom_range(3) == 0) pb = !pb;
      sb  = ($urandom_range(4) != 0);
      parity_en  = pen;
      parity_odd = odd;
      fork
        sendFrame(d, pen, pb, sb);
        begin
          waitTicks(OS * 3);
          parity_en  = 1'($urandom);
          parity_odd = 1'($urandom);
        end
      join
      if (!sb) begin
        waitTicks(OS * 3);
      end
      idle($urandom_range(20, 2));
      checkFrame("rnd", d, pen, odd, pb, sb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
